// File: rtl/mma_tile_sequencer_pkg.sv
// mma_pkg: shared constants, state encoding and packed-bus offset helper for the MMA tile sequencer.
package mma_pkg;
  localparam int DIM = 4;
  localparam int NELEM = DIM * DIM;
  localparam int INT8_W = 8;
  localparam int INT32_W = 32;
  typedef enum logic [2:0] {S_LOAD_A, S_LOAD_B, S_LOAD_C, S_ISSUE, S_WAIT, S_DRAIN} state_t;
  function automatic int unsigned elem_off(input int unsigned i, input int unsigned j, input int unsigned w);
    return (DIM * i + j) * w;
  endfunction
endpackage

// File: rtl/mma_tile_sequencer_if.sv
// mma_tile_sequencer_if: load stream, tensor-core handshake and result stream between sequencer and its neighbours.
interface mma_tile_sequencer_if
  import mma_pkg::*;
#(parameter int W8 = INT8_W, parameter int W32 = INT32_W);
  logic in_valid, in_ready;
  logic [W32-1:0] in_data;
  logic mma_valid, mma_ready, result_valid;
  logic [NELEM*W8-1:0] mma_a, mma_b;
  logic [NELEM*W32-1:0] mma_c, mma_d;
  logic out_valid, out_ready, out_last;
  logic [W32-1:0] out_data;
  modport master (
    input in_valid, in_data, mma_ready, result_valid, mma_d, out_ready,
    output in_ready, mma_valid, mma_a, mma_b, mma_c, out_valid, out_data, out_last
  );
  modport slave (
    output in_valid, in_data, mma_ready, result_valid, mma_d, out_ready,
    input in_ready, mma_valid, mma_a, mma_b, mma_c, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mma_tile_sequencer.sv
// mma_tile_sequencer: assembles A/B/C tiles from a serial stream, issues one MMA per tile and drains D serially.
module mma_tile_sequencer
  import mma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int INT8_WIDTH = INT8_W,
  parameter int INT32_WIDTH = INT32_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_accum,
  output logic        mma_enable,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] tiles_done,
  mma_tile_sequencer_if.master bus
);
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [WCW-1:0] W_ONE = WCW'(1);
  state_t state, next_state;
  logic [3:0] idx;
  logic [WCW-1:0] wcnt;
  logic accum;
  logic [NELEM*INT8_WIDTH-1:0] a_q, b_q;
  logic [NELEM*INT32_WIDTH-1:0] c_q, d_q, prev_d;
  logic in_acc, out_acc, mma_hs, idx_last, tmo;
  int unsigned off8, off32;
  assign idx_last = idx == 4'd15;
  assign in_acc = bus.in_valid && bus.in_ready;
  assign out_acc = bus.out_valid && bus.out_ready;
  assign mma_hs = bus.mma_valid && bus.mma_ready;
  assign tmo = state == S_WAIT && !bus.result_valid && wcnt == W_LAST;
  assign off8 = elem_off(int'(idx[3:2]), int'(idx[1:0]), INT8_WIDTH);
  assign off32 = elem_off(int'(idx[3:2]), int'(idx[1:0]), INT32_WIDTH);
  assign bus.mma_a = a_q;
  assign bus.mma_b = b_q;
  assign bus.mma_c = c_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_LOAD_A;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      S_LOAD_A: if (in_acc && idx_last) next_state = S_LOAD_B;
      S_LOAD_B: if (in_acc && idx_last) next_state = accum ? S_ISSUE : S_LOAD_C;
      S_LOAD_C: if (in_acc && idx_last) next_state = S_ISSUE;
      S_ISSUE:  if (mma_hs) next_state = S_WAIT;
      S_WAIT:   next_state = bus.result_valid ? S_DRAIN : tmo ? S_LOAD_A : S_WAIT;
      S_DRAIN:  if (out_acc && idx_last) next_state = S_LOAD_A;
      default:  next_state = S_LOAD_A;
    endcase
  end
  always_comb begin
    mma_enable = rst_n;
    bus.in_ready = state inside {S_LOAD_A, S_LOAD_B, S_LOAD_C};
    bus.mma_valid = state == S_ISSUE;
    bus.out_valid = state == S_DRAIN;
    bus.out_last = state == S_DRAIN && idx_last;
    bus.out_data = state == S_DRAIN ? d_q[off32 +: INT32_WIDTH] : '0;
    busy = state != S_LOAD_A || idx != 4'd0;
  end
  // Operands only change on load beats, so they stay frozen through ISSUE and WAIT.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      wcnt <= '0;
      accum <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      prev_d <= '0;
      err_timeout <= 1'b0;
      tiles_done <= '0;
    end else begin
      wcnt <= state == S_WAIT ? wcnt + W_ONE : '0;
      if (in_acc || out_acc) idx <= idx + 4'd1;
      if (tmo) begin
        idx <= '0;
        err_timeout <= 1'b1;
      end
      if (in_acc && state == S_LOAD_A) begin
        a_q[off8 +: INT8_WIDTH] <= bus.in_data[INT8_WIDTH-1:0];
        if (idx == 4'd0) accum <= cfg_accum;
      end
      if (in_acc && state == S_LOAD_B) b_q[off8 +: INT8_WIDTH] <= bus.in_data[INT8_WIDTH-1:0];
      if (in_acc && state == S_LOAD_B && idx_last && accum) c_q <= prev_d;
      if (in_acc && state == S_LOAD_C) c_q[off32 +: INT32_WIDTH] <= bus.in_data[INT32_WIDTH-1:0];
      if (state == S_WAIT && bus.result_valid) begin
        d_q <= bus.mma_d;
        prev_d <= bus.mma_d;
      end
      if (out_acc && idx_last) tiles_done <= tiles_done + 16'd1;
    end
endmodule

// File: doc/mma_tile_sequencer.md
# mma_tile_sequencer

Initiator-side controller for the 4x4 INT8 tensor core MMA handshake. It assembles A, B and C tiles from a serial 32-bit load stream and issues one `mma_valid` pulse per tile. It then captures D when `result_valid` pulses and drains D as a 16-beat serial result stream. It sits between the operand fetch path and the tensor core, and supports chained accumulation, where C is replaced by the previous D.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles in WAIT before the block aborts.
- `INT8_WIDTH`, default 8: A and B element width.
- `INT32_WIDTH`, default 32: C and D element width, and stream data width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_accum`  in  1  1 = use the previous D as C, and skip the C load beats.
- `in_valid`  in  1  load stream valid.
- `in_ready`  out  1  load stream ready.
- `in_data`  in  32  load element. For A and B, only [7:0] is used.
- `mma_enable`  out  1  core enable.
- `mma_valid`  out  1  issue request to the core.
- `mma_ready`  in  1  core ready.
- `result_valid`  in  1  core result pulse.
- `mma_a`, `mma_b`  out  128 each  element (i,j) at bits [(4i+j)*8 +: 8].
- `mma_c`  out  512  element (i,j) at bits [(4i+j)*32 +: 32].
- `mma_d`  in  512  same packing as `mma_c`.
- `out_valid`  out  1  result stream valid.
- `out_ready`  in  1  result stream ready.
- `out_data`  out  32  D element.
- `out_last`  out  1  high on the 16th result beat.
- `busy`  out  1  state is not LOAD_A, or the element index is nonzero.
- `err_timeout`  out  1  sticky; set when WAIT expires.
- `tiles_done`  out  16  count of completed drains; wraps modulo 2^16.

## Operation

States and transitions:
- LOAD_A: accept 16 beats, then go to LOAD_B.
- LOAD_B: accept 16 beats, then go to LOAD_C, or to ISSUE when the accumulate mode is 1.
- LOAD_C: accept 16 beats, then go to ISSUE.
- ISSUE: go to WAIT on `mma_valid && mma_ready`.
- WAIT: go to DRAIN on `result_valid`, or back to LOAD_A on timeout.
- DRAIN: emit 16 beats, then go to LOAD_A.

Load stream:
- Elements arrive row-major, index 0..15.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` is 1 in the LOAD states and 0 in all other states.
- The accumulate mode is `cfg_accum`, sampled on the first accepted A beat (index 0) and held for the whole tile.

Accumulate:
- The C register is loaded with the previous D, from a prev-D register.
- prev-D is 0 after reset. It is updated with every captured D.

Operand registers:
- The A, B and C registers drive `mma_a`, `mma_b` and `mma_c` directly.
- They must not change from entry into ISSUE until exit from WAIT, because the core samples them during its compute cycle.

Issue:
- `mma_valid` is 1 exactly while in ISSUE.
- `mma_enable` is 1 whenever `rst_n` is deasserted.

Capture:
- In WAIT, `mma_d` is latched into the D register on the edge where `result_valid` is 1.

Drain:
- `out_data` is the D element at the element index.
- `out_valid` is 1 throughout DRAIN.
- Data advances only on a beat handshake.
- `tiles_done` increments when the last beat is accepted.

Timeout:
- A WAIT cycle counter runs from 0.
- When it reaches `TIMEOUT_CYCLES-1` without `result_valid`, the block sets `err_timeout`, discards the tile and goes to LOAD_A.
- `err_timeout` is cleared only by reset.

Width rules:
- A and B elements are `in_data[7:0]`, treated as signed.
- C and D elements are the full 32 bits.
- The block does no arithmetic on data.

## Timing

Reset values:
- State is LOAD_A, with element index 0.
- `in_ready` = 1.
- `mma_valid` = 0.
- `mma_enable` = 0 while `rst_n` is low.
- `out_valid` = 0 and `out_last` = 0.
- `busy` = 0 and `err_timeout` = 0.
- `tiles_done` = 0.
- All of A, B, C, D, prev-D and `out_data` are 0.

Latency:
- The last load beat is accepted at edge N.
- `mma_valid` is high from edge N, and the handshake completes at N+1 if `mma_ready` was high.
- The core computes in the next cycle, and `result_valid` is high after N+2.
- D is captured at edge N+3, and `out_valid` is high after N+3.
- With `out_ready` held at 1, the drain takes 16 cycles.

Handshake rules:
- `mma_valid` is held until `mma_ready` is seen, and drops on the cycle after the handshake.
- `out_valid`, `out_data` and `out_last` hold stable while `out_ready` = 0.

Boundary conditions:
- A beat presented in a non-LOAD state is not accepted.
- If `result_valid` is seen in any state other than WAIT, it is ignored.
- `cfg_accum` changing mid-tile has no effect.
- A timeout resets the element index and leaves prev-D unchanged.
- Reset asserted mid-operation clears everything asynchronously, including prev-D; on release the block starts in LOAD_A.

## Structure

- Package `mma_pkg` holds:
  - DIM = 4 and the width constants;
  - the state enum;
  - a function that gives the packed-bus bit offset for element (i,j).
- Single module. A shared 4-bit element counter serves the LOAD and DRAIN phases, and a separate WAIT counter serves the timeout.
- The bench instantiates the team's INT8 tensor core as the responder.

## Test plan

- A = 2 on the diagonal and 1 elsewhere; B = all ones; C = 0 except c00 = 3, c20 = 2, c22 = 5 -> rows of D are [8,5,5,5], [5,5,5,5], [7,5,10,5], [5,5,5,5]; `out_last` on beat 16; `tiles_done` = 1.
- Same tile, then `cfg_accum` = 1 with the same A and B (32 load beats only) -> D doubles the A×B part and keeps C: row 0 = [13,10,10,10].
- Random `in_valid` and `out_ready` gaps (50%) over 8 tiles -> D matches a reference model; stream outputs stay stable under backpressure.
- A tensor core model that never asserts `result_valid`, with `TIMEOUT_CYCLES` = 64 -> `err_timeout` = 1 after 64 WAIT cycles, no `out_valid`, block back in LOAD_A with `in_ready` = 1.
- A = -128 everywhere and B = -1 everywhere -> every D element = 512.
- Reset asserted mid-DRAIN -> all outputs at their reset values immediately; the next tile in accumulate mode uses C = 0.
